// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Response addresses are carried at this width; ADDR_W must not exceed it.
  localparam int RSP_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]           data;
    logic [RSP_ADDR_W-1:0] addr;
    logic                  err;
  } rsp_t;

  function automatic logic [2:0] latency_preload(input int latency);
    return 3'(latency - 1);
  endfunction

endpackage

// File: rtl/imem_store.sv
// Word-addressed instruction array: synchronous write, combinational read.
module imem_store #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  // Contents are deliberately not reset; the program is written through the load port.
  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch in flight, fixed latency, flushable.
// Define IMEM_ERR_EN to flag misaligned/out-of-range fetches and return a NOP.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_LOAD = latency_preload(LATENCY);

  fetch_state_t state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  rsp_t         rsp_q, rsp_d;
  logic         rsp_valid_q, rsp_valid_d;

  logic [31:0]  rd_data;
  logic [31:0]  fetch_data;
  logic         fetch_err;
  logic         accept;
  logic         unused_ld_bits;

  // The load port only ever addresses whole words inside the array.
  assign unused_ld_bits = ^{ld_addr[ADDR_W-1:IDX_W+2], ld_addr[1:0]};

  imem_store #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_store (
    .clk     (clk),
    .wr_en   (ld_we),
    .wr_idx  (ld_addr[IDX_W+1:2]),
    .wr_data (ld_data),
    .rd_idx  (req_addr[IDX_W+1:2]),
    .rd_data (rd_data)
  );

`ifdef IMEM_ERR_EN
  // Power-of-two depth: any set bit above the word index means out of range.
  assign fetch_err  = (|req_addr[1:0]) | (|req_addr[ADDR_W-1:IDX_W+2]);
  assign fetch_data = fetch_err ? NOP_INSTR : rd_data;
`else
  assign fetch_err  = 1'b0;
  assign fetch_data = rd_data;
`endif

  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready) || flush;
  assign accept    = req_valid && req_ready;

  // Flush drops the current transaction; an acceptance in the same cycle wins over both.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rsp_d   = rsp_q;

    case (state_q)
      BUSY: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end

    if (accept) begin
      rsp_d.data = fetch_data;
      rsp_d.addr = RSP_ADDR_W'(req_addr);
      rsp_d.err  = fetch_err;
      cnt_d      = CNT_LOAD;
      state_d    = (LATENCY == 1) ? RESP : BUSY;
    end

    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_q.data;
  assign rsp_addr  = rsp_q.addr[ADDR_W-1:0];
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed self-checking bench: a LATENCY=2 responder and a LATENCY=1 responder share inputs.
module tb_imem_responder;

  localparam logic [31:0] W0 = 32'h0050_0093;
  localparam logic [31:0] W1 = 32'h0010_8113;
  localparam logic [31:0] W2 = 32'h0020_81b3;
  localparam logic [31:0] W3 = 32'h4020_8233;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_ready;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data, rsp_addr;
  logic        l1_req_ready, l1_rsp_valid, l1_rsp_err;
  logic [31:0] l1_rsp_data, l1_rsp_addr;

  int vectors;
  int miscompares;

  imem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .ADDR_W(32)) dut_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(l1_req_ready),
    .req_addr(req_addr), .flush(flush), .rsp_valid(l1_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(l1_rsp_data), .rsp_addr(l1_rsp_addr), .rsp_err(l1_rsp_err),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_we   = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid: got %h expected 0", rsp_valid); end
    vectors++;
    if (rsp_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    vectors++;
    if (rsp_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rsp_addr: got %h expected 0", rsp_addr); end
    vectors++;
    if (rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_err: got %h expected 0", rsp_err); end
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %h expected 1", req_ready); end
    vectors++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    rsp_ready = 1'b1;
    #1;
    if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL lat_req_ready: got %h expected 1", req_ready); end
    vectors++;
    tick();
    req_valid = 1'b0;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL lat_early_valid: got %h expected 0", rsp_valid); end
    vectors++;
    tick();
    if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL lat_valid: got %h expected 1", rsp_valid); end
    vectors++;
    if (rsp_data !== W0) begin miscompares++; $display("[TB] FAIL lat_data: got %h expected %h", rsp_data, W0); end
    vectors++;
    if (rsp_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL lat_addr: got %h expected 0", rsp_addr); end
    vectors++;
    if (rsp_err !== 1'b0) begin miscompares++; $display("[TB] FAIL lat_err: got %h expected 0", rsp_err); end
    vectors++;
    tick();
    if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL lat_release: got %h expected 0", rsp_valid); end
    vectors++;
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h8;
    tick();
    req_addr = 32'h4;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_valid[%0d]: got %h expected 1", i, rsp_valid); end
      vectors++;
      if (rsp_data !== W2) begin miscompares++; $display("[TB] FAIL bp_data[%0d]: got %h expected %h", i, rsp_data, W2); end
      vectors++;
      if (rsp_addr !== 32'h8) begin miscompares++; $display("[TB] FAIL bp_addr[%0d]: got %h expected 8", i, rsp_addr); end
      vectors++;
      if (req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_req_ready[%0d]: got %h expected 0", i, req_ready); end
      vectors++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_release_ready: got %h expected 1", req_ready); end
    vectors++;
    tick();
    req_valid = 1'b0;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_busy_valid: got %h expected 0", rsp_valid); end
    vectors++;
    tick();
    if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_next_valid: got %h expected 1", rsp_valid); end
    vectors++;
    if (rsp_data !== W1) begin miscompares++; $display("[TB] FAIL bp_next_data: got %h expected %h", rsp_data, W1); end
    vectors++;
    if (rsp_addr !== 32'h4) begin miscompares++; $display("[TB] FAIL bp_next_addr: got %h expected 4", rsp_addr); end
    vectors++;
    tick();
  endtask

  task automatic test_flush;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    flush    = 1'b1;
    req_addr = 32'h4;
    #1;
    if (req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_req_ready: got %h expected 1", req_ready); end
    vectors++;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_busy_valid: got %h expected 0", rsp_valid); end
    vectors++;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_dropped_valid: got %h expected 0", rsp_valid); end
    vectors++;
    tick();
    if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_target_valid: got %h expected 1", rsp_valid); end
    vectors++;
    if (rsp_addr !== 32'h4) begin miscompares++; $display("[TB] FAIL flush_target_addr: got %h expected 4", rsp_addr); end
    vectors++;
    if (rsp_data !== W1) begin miscompares++; $display("[TB] FAIL flush_target_data: got %h expected %h", rsp_data, W1); end
    vectors++;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_quiet[%0d]: got %h expected 0", i, rsp_valid); end
      vectors++;
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [3];
    logic [31:0] words [3];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    words[0] = W0;    words[1] = W1;    words[2] = W2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = addrs[i];
      #1;
      if (l1_req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_req_ready[%0d]: got %h expected 1", i, l1_req_ready); end
      vectors++;
      tick();
      if (l1_rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_valid[%0d]: got %h expected 1", i, l1_rsp_valid); end
      vectors++;
      if (l1_rsp_addr !== addrs[i]) begin miscompares++; $display("[TB] FAIL b2b_addr[%0d]: got %h expected %h", i, l1_rsp_addr, addrs[i]); end
      vectors++;
      if (l1_rsp_data !== words[i]) begin miscompares++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, l1_rsp_data, words[i]); end
      vectors++;
    end
    req_valid = 1'b0;
    tick();
    if (l1_rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drain: got %h expected 0", l1_rsp_valid); end
    vectors++;
    tick();
  endtask

  task automatic test_err;
    logic [31:0] addrs [2];
    logic        exp_err;
    logic [31:0] exp_data;
    addrs[0] = 32'h2;
    addrs[1] = 32'h400;
`ifdef IMEM_ERR_EN
    exp_err  = 1'b1;
    exp_data = 32'h0000_0013;
`else
    exp_err  = 1'b0;
    exp_data = W0;
`endif
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1;
      req_addr  = addrs[i];
      tick();
      req_valid = 1'b0;
      tick();
      if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL err_valid[%0d]: got %h expected 1", i, rsp_valid); end
      vectors++;
      if (rsp_err !== exp_err) begin miscompares++; $display("[TB] FAIL err_flag[%0d]: got %h expected %h", i, rsp_err, exp_err); end
      vectors++;
      if (rsp_data !== exp_data) begin miscompares++; $display("[TB] FAIL err_data[%0d]: got %h expected %h", i, rsp_data, exp_data); end
      vectors++;
      if (rsp_addr !== addrs[i]) begin miscompares++; $display("[TB] FAIL err_addr[%0d]: got %h expected %h", i, rsp_addr, addrs[i]); end
      vectors++;
      tick();
    end
  endtask

  task automatic test_load_collision;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'hC;
    ld_we     = 1'b1;
    ld_addr   = 32'hC;
    ld_data   = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0;
    ld_data   = 32'h1234_5678;
    tick();
    ld_we = 1'b0;
    if (rsp_data !== W3) begin miscompares++; $display("[TB] FAIL ld_old_data: got %h expected %h", rsp_data, W3); end
    vectors++;
    if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL ld_old_valid: got %h expected 1", rsp_valid); end
    vectors++;
    tick();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    if (rsp_data !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL ld_new_data: got %h expected 12345678", rsp_data); end
    vectors++;
    tick();
  endtask

  task automatic test_reset_midfetch;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h4;
    tick();
    req_valid = 1'b0;
    if (rsp_data !== W1) begin miscompares++; $display("[TB] FAIL rst_capture: got %h expected %h", rsp_data, W1); end
    vectors++;
    #2;
    reset = 1'b1;
    #1;
    if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_async_valid: got %h expected 0", rsp_valid); end
    vectors++;
    if (rsp_data !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_async_data: got %h expected 0", rsp_data); end
    vectors++;
    if (rsp_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_async_addr: got %h expected 0", rsp_addr); end
    vectors++;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_no_stale[%0d]: got %h expected 0", i, rsp_valid); end
      vectors++;
      tick();
    end
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    if (rsp_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_new_valid: got %h expected 1", rsp_valid); end
    vectors++;
    if (rsp_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_new_addr: got %h expected 0", rsp_addr); end
    vectors++;
    if (rsp_data !== W0) begin miscompares++; $display("[TB] FAIL rst_new_data: got %h expected %h", rsp_data, W0); end
    vectors++;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_addr    = 32'h0;
    flush       = 1'b0;
    rsp_ready   = 1'b0;
    ld_we       = 1'b0;
    ld_addr     = 32'h0;
    ld_data     = 32'h0;

    test_reset();
    load_word(32'h0, W0);
    load_word(32'h4, W1);
    load_word(32'h8, W2);
    load_word(32'hC, W3);
    tick();

    test_latency();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_err();
    test_load_collision();
    test_reset_midfetch();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
